vc_arbiter: RTL
===============

# vc_arbiter

Downstream stage of the VC0/VC1 virtual-channel FIFOs in the PCIe QoS path. Pops words from both VC FIFOs under a weighted priority scheme (VC0 favoured), steers each word to one of two destination FIFOs by its destination bit, and stalls on destination almost-full. All outputs to the destination FIFOs are registered.

## Interface
Parameters:
- BW, 16, word width; bit BW-1 is the destination select (0 → D0, 1 → D1)
- WEIGHT, 3, maximum consecutive VC0 grants while VC1 is also eligible (1..15)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset_L  input  1  asynchronous, active-low reset
- arb_en  input  1  1 = arbitration enabled; 0 = no new pops, in-flight words drain
- VC0_empty  input  1  VC0 FIFO empty flag
- VC0_data_out  input  BW  VC0 FIFO read data
- VC0_rd  output  1  VC0 pop request
- VC1_empty  input  1  VC1 FIFO empty flag
- VC1_data_out  input  BW  VC1 FIFO read data
- VC1_rd  output  1  VC1 pop request
- D0_almost_full  input  1  destination 0 almost-full
- D1_almost_full  input  1  destination 1 almost-full
- D0_push  output  1  write strobe, destination 0
- D0_data  output  BW  write data, destination 0
- D1_push  output  1  write strobe, destination 1
- D1_data  output  BW  write data, destination 1
- idle  output  1  1 = nothing in flight and both VCs empty

## Operation
- Reset: VC0_rd=VC1_rd=0, D0_push=D1_push=0, D0_data=D1_data=0, idle=1, weight counter=0, pipeline valid bits=0.
- Stall: `stall = D0_almost_full | D1_almost_full | ~arb_en`. Both destinations are gated because the destination bit is only visible after the pop.
- Eligibility: VCn eligible = `~VCn_empty & ~stall`.
- Grant, combinational, at most one per cycle:
  - Only one VC eligible: grant it.
  - Both eligible and cnt < WEIGHT: grant VC0.
  - Both eligible and cnt = WEIGHT: grant VC1.
  - VCn_rd = grant to VCn.
- Weight counter cnt, 4 bits:
  - Increments on a VC0 grant while VC1 is eligible.
  - Clears on any VC1 grant, or on a VC0 grant while VC1 is not eligible.
  - Holds when there is no grant.
  - Never exceeds WEIGHT.
- Pipeline:
  - Stage 1 register (rd_vld, rd_src) captures the grant.
  - On the following cycle, the word is selected from VC0_data_out or VC1_data_out per rd_src.
  - That word is routed by bit BW-1 into the D0 or D1 output register, with the matching push.
- Non-target data output holds its last value. push is a single-cycle pulse per word.
- idle = `~rd_vld & ~D0_push & ~D1_push & VC0_empty & VC1_empty`, registered.

## Timing
- VC FIFOs present read data in the cycle after rd is asserted. VCn_empty reflects occupancy after any read at the preceding edge.
- Grant at cycle t → rd high in t → data sampled at end of t+1 → Dx_push high in t+2. Pop-to-push latency is 2 cycles.
- Throughput: one word per cycle sustained.
- Backpressure: after Dx_almost_full is first seen high, up to 2 further pushes occur (words already in flight). Destination almost-full threshold must leave ≥2 free entries.
- arb_en deasserted: takes effect the same cycle (no rd). In-flight words still push.
- Single-entry VC: rd at t, empty high at t+1, no second pop. A VC FIFO never underflows.
- Asynchronous reset mid-flight: in-flight words are discarded; all outputs go to reset values immediately.

## Structure
- Shared package: destination-bit index (BW-1), VC index encoding (VC0=0, VC1=1), counter width constant.
- One natural sub-module: `wrr_grant`, the combinational grant logic plus the weight-counter register.
- The pipeline and routing registers stay in the top module.

## Test plan
- Only VC0 loaded with 4 words, alternating dest bits 0/1/0/1, destinations not full:
  - VC0_rd high for 4 consecutive cycles.
  - D0_push and D1_push alternate, starting 2 cycles after the first rd.
  - Data matches in order.
- Both VCs loaded with 10 words each, WEIGHT=3: grant pattern 0,0,0,1,0,0,0,1,… until VC1 is empty.
- D1_almost_full asserted mid-stream: rd stops the same cycle, at most 2 further pushes occur, no words are lost. Deasserting resumes pops.
- Single-word VC1 plus an empty VC0: exactly one VC1_rd pulse, one push, idle returns to 1 three cycles later.
- reset_L low during streaming: pushes and rd are 0 immediately. After reset release with empty VCs, no push occurs and idle=1.
- arb_en=0 with full VCs: no rd. Raising arb_en starts popping on the same cycle.

Source files
------------

// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the VC0/VC1 weighted arbiter: VC encoding, counter width,
// and the position of the destination-select bit inside a word.
package vc_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

  // The destination select is always the word's MSB.
  function automatic int dest_bit(input int bw);
    return bw - 1;
  endfunction

endpackage

// File: rtl/wrr_grant.sv
// Weighted grant between VC0 and VC1: VC0 wins up to WEIGHT times in a row while
// VC1 is waiting, then VC1 gets one grant.
module wrr_grant
  import vc_arbiter_pkg::*;
#(
  parameter int WEIGHT = 3
) (
  input  logic clk,
  input  logic reset_L,
  input  logic i_elig0,
  input  logic i_elig1,
  output logic o_grant0,
  output logic o_grant1
);

  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(WEIGHT);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (i_elig0 && i_elig1) begin
      if (r_cnt < W_MAX) o_grant0 = 1'b1;
      else               o_grant1 = 1'b1;
    end else begin
      o_grant0 = i_elig0;
      o_grant1 = i_elig1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt <= '0;
    end else if (o_grant1 || (o_grant0 && !i_elig1)) begin
      r_cnt <= '0;
    end else if (o_grant0) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Pops the VC0/VC1 FIFOs under weighted priority and steers each word by its MSB
// into the D0 or D1 destination FIFO through registered push/data outputs.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int BW     = 16,
  parameter int WEIGHT = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          arb_en,
  input  logic          VC0_empty,
  input  logic [BW-1:0] VC0_data_out,
  output logic          VC0_rd,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC1_data_out,
  output logic          VC1_rd,
  input  logic          D0_almost_full,
  input  logic          D1_almost_full,
  output logic          D0_push,
  output logic [BW-1:0] D0_data,
  output logic          D1_push,
  output logic [BW-1:0] D1_data,
  output logic          idle
);

  localparam int DEST = dest_bit(BW);

  logic          w_stall;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_grant0;
  logic          w_grant1;
  logic [BW-1:0] w_word;

  logic          r_rd_vld;
  vc_e           r_rd_src;
  logic          r_d0_push;
  logic          r_d1_push;
  logic [BW-1:0] r_d0_data;
  logic [BW-1:0] r_d1_data;
  logic          r_idle;

  // Either destination nearing full blocks both: the target is unknown until after the pop.
  // Reset is folded in so the combinational pop requests drop the instant reset asserts.
  assign w_stall = D0_almost_full | D1_almost_full | ~arb_en | ~reset_L;
  assign w_elig0 = ~VC0_empty & ~w_stall;
  assign w_elig1 = ~VC1_empty & ~w_stall;

  wrr_grant #(
    .WEIGHT (WEIGHT)
  ) u_wrr_grant (
    .clk      (clk),
    .reset_L  (reset_L),
    .i_elig0  (w_elig0),
    .i_elig1  (w_elig1),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  assign VC0_rd = w_grant0;
  assign VC1_rd = w_grant1;

  // FIFO read data is valid the cycle after the pop, while r_rd_vld marks it.
  assign w_word = (r_rd_src == VC1) ? VC1_data_out : VC0_data_out;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rd_vld  <= 1'b0;
      r_rd_src  <= VC0;
      r_d0_push <= 1'b0;
      r_d1_push <= 1'b0;
      r_d0_data <= '0;
      r_d1_data <= '0;
      r_idle    <= 1'b1;
    end else begin
      r_rd_vld  <= w_grant0 | w_grant1;
      r_rd_src  <= w_grant1 ? VC1 : VC0;
      r_d0_push <= r_rd_vld & ~w_word[DEST];
      r_d1_push <= r_rd_vld &  w_word[DEST];
      if (r_rd_vld && !w_word[DEST]) r_d0_data <= w_word;
      if (r_rd_vld &&  w_word[DEST]) r_d1_data <= w_word;
      r_idle    <= ~r_rd_vld & ~r_d0_push & ~r_d1_push & VC0_empty & VC1_empty;
    end
  end

  assign D0_push = r_d0_push;
  assign D1_push = r_d1_push;
  assign D0_data = r_d0_data;
  assign D1_data = r_d1_data;
  assign idle    = r_idle;

endmodule
